ahb_lite_sram_slave: RTL and testbench

AHB-Lite responder (slave) with word-organised internal SRAM, the completion side of the transfers issued by the Cortex-M0 master port. It sits behind the AHB decoder/mux, selected by HSEL. It supports byte, halfword and word reads and writes, a programmable number of wait states, and optional ERROR responses for illegal transfers.

---
 rtl/ahb_lite_sram_slave.sv | 131 +++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM responder: byte/half/word access, programmable wait states.
// Define AHB_SLV_ERR_EN to enable two-cycle ERROR responses for illegal transfers.
module ahb_lite_sram_slave #(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [3:0]  i_hsize,
    input  logic [31:0] i_hwdata,
    input  logic        i_hready,
    output logic        o_hreadyout,
    output logic        o_hresp,
    output logic [31:0] o_hrdata
);

    localparam int         DEPTH   = 1 << (ADDR_WIDTH - 2);
    localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
`ifdef AHB_SLV_ERR_EN
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;
`endif

    logic [31:0]           r_mem [0:DEPTH-1];
    logic [2:0]            r_state;
    logic [2:0]            r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_write;
    logic [2:0]            r_size;

    logic [2:0] w_next_state;
    logic [2:0] w_next_cnt;
    logic       w_ready;
    logic       w_accept;
    logic [3:0] w_be;
    logic       w_unused;

    assign w_unused = &{1'b0, i_haddr[31:ADDR_WIDTH], i_hsize[3], i_htrans[0]};

`ifdef AHB_SLV_ERR_EN
    logic w_illegal;
    assign w_illegal = (i_hsize[2:0] > 3'd2)
                     | ((i_hsize[2:0] == 3'd1) & i_haddr[0])
                     | ((i_hsize[2:0] == 3'd2) & (i_haddr[1:0] != 2'b00));
    assign w_ready = (r_state != S_WAIT) && (r_state != S_ERR1);
    assign o_hresp = (r_state == S_ERR1) || (r_state == S_ERR2);
`else
    assign w_ready = (r_state != S_WAIT);
    assign o_hresp = 1'b0;
`endif

    // Gating with our own ready keeps a stalled transfer's controls intact.
    assign w_accept    = i_hsel & i_htrans[1] & i_hready & w_ready;
    assign o_hreadyout = w_ready;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_WAIT: begin
                w_next_cnt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) w_next_state = S_DATA;
            end
`ifdef AHB_SLV_ERR_EN
            S_ERR1: w_next_state = S_ERR2;
`endif
            default: begin
                w_next_state = S_IDLE;
                if (w_accept) begin
`ifdef AHB_SLV_ERR_EN
                    if (w_illegal) w_next_state = S_ERR1;
                    else
`endif
                    if (LP_WAIT != 3'd0) begin
                        w_next_state = S_WAIT;
                        w_next_cnt   = LP_WAIT;
                    end else begin
                        w_next_state = S_DATA;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_addr  <= i_haddr[ADDR_WIDTH-1:0];
                r_write <= i_hwrite;
                r_size  <= i_hsize[2:0];
            end
        end
    end

    // Size >2 and misaligned offsets fall through to aligned-down lanes.
    always_comb begin
        case (r_size)
            3'd0:    w_be = 4'b0001 << r_addr[1:0];
            3'd1:    w_be = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_be = 4'b1111;
        endcase
    end

    always_ff @(posedge i_hclk) begin
        if (!i_hreset && (r_state == S_DATA) && r_write) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[r_addr[ADDR_WIDTH-1:2]][8*b +: 8] <= i_hwdata[8*b +: 8];
            end
        end
    end

    assign o_hrdata = ((r_state == S_WAIT || r_state == S_DATA) && !r_write)
                      ? r_mem[r_addr[ADDR_WIDTH-1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: one instance with zero wait states, one with three.
// Expectations follow AHB_SLV_ERR_EN when it is defined for the build.
module tb_ahb_lite_sram_slave;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel0 = 1'b0;
    logic        hsel3 = 1'b0;
    logic [31:0] haddr = 32'h0;
    logic [1:0]  htrans = 2'b00;
    logic        hwrite = 1'b0;
    logic [3:0]  hsize = 4'd0;
    logic [31:0] hwdata = 32'h0;
    logic        rdy0, resp0, rdy3, resp3;
    logic [31:0] rdata0, rdata3;
    int          nChecks = 0;
    int          nErrors = 0;

    always #5 hclk = ~hclk;

    ahb_lite_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .i_hclk(hclk), .i_hreset(hreset), .i_hsel(hsel0), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(rdy0), .o_hreadyout(rdy0), .o_hresp(resp0), .o_hrdata(rdata0)
    );

    ahb_lite_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(3)) dut3 (
        .i_hclk(hclk), .i_hreset(hreset), .i_hsel(hsel3), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(rdy3), .o_hreadyout(rdy3), .o_hresp(resp3), .o_hrdata(rdata3)
    );

    function automatic logic selRdy(input int d);
        return (d == 1) ? rdy3 : rdy0;
    endfunction

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drive_addr(input int d, input logic [31:0] a, input logic wr, input logic [2:0] sz);
        hsel0  = (d == 0);
        hsel3  = (d == 1);
        haddr  = a;
        htrans = 2'b10;
        hwrite = wr;
        hsize  = {1'b0, sz};
    endtask

    task automatic drive_idle();
        hsel0  = 1'b0;
        hsel3  = 1'b0;
        htrans = 2'b00;
    endtask

    task automatic wait_ready(input int d, input string name);
        int n = 0;
        while (selRdy(d) == 1'b0 && n < 20) begin
            n++;
            tick();
        end
        nChecks++;
        if (n >= 20) begin
            nErrors++;
            $display("[TB] FAIL %s: HREADYOUT stuck low after %0d cycles, required high", name, n);
        end
    endtask

    task automatic do_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] data);
        drive_addr(d, a, 1'b1, sz);
        tick();
        hwdata = data;
        drive_idle();
        wait_ready(d, "write_timeout");
        tick();
    endtask

    task automatic do_read(input int d, input logic [31:0] a, input logic [2:0] sz,
                           output logic [31:0] data, output logic resp);
        drive_addr(d, a, 1'b0, sz);
        tick();
        drive_idle();
        wait_ready(d, "read_timeout");
        data = (d == 1) ? rdata3 : rdata0;
        resp = (d == 1) ? resp3 : resp0;
        tick();
    endtask

    task automatic test_reset();
        hreset = 1'b1;
        drive_idle();
        tick();
        tick();
        nChecks += 6;
        if (rdy0 !== 1'b1)     begin nErrors++; $display("[TB] FAIL reset_rdy0: got %b expected 1", rdy0); end
        if (resp0 !== 1'b0)    begin nErrors++; $display("[TB] FAIL reset_resp0: got %b expected 0", resp0); end
        if (rdata0 !== 32'h0)  begin nErrors++; $display("[TB] FAIL reset_rdata0: got %h expected 0", rdata0); end
        if (rdy3 !== 1'b1)     begin nErrors++; $display("[TB] FAIL reset_rdy3: got %b expected 1", rdy3); end
        if (resp3 !== 1'b0)    begin nErrors++; $display("[TB] FAIL reset_resp3: got %b expected 0", resp3); end
        if (rdata3 !== 32'h0)  begin nErrors++; $display("[TB] FAIL reset_rdata3: got %h expected 0", rdata3); end
        hreset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        drive_addr(0, 32'h010, 1'b1, 3'd2);
        tick();
        hwdata = 32'hDEADBEEF;
        drive_addr(0, 32'h010, 1'b0, 3'd2);
        nChecks += 2;
        if (rdy0 !== 1'b1)  begin nErrors++; $display("[TB] FAIL b2b_wr_rdy: got %b expected 1", rdy0); end
        if (resp0 !== 1'b0) begin nErrors++; $display("[TB] FAIL b2b_wr_resp: got %b expected 0", resp0); end
        tick();
        drive_idle();
        nChecks += 3;
        if (rdy0 !== 1'b1)          begin nErrors++; $display("[TB] FAIL b2b_rd_rdy: got %b expected 1", rdy0); end
        if (rdata0 !== 32'hDEADBEEF) begin nErrors++; $display("[TB] FAIL b2b_rd_data: got %h expected deadbeef", rdata0); end
        if (resp0 !== 1'b0)         begin nErrors++; $display("[TB] FAIL b2b_rd_resp: got %b expected 0", resp0); end
        tick();
        nChecks += 2;
        if (rdy0 !== 1'b1)   begin nErrors++; $display("[TB] FAIL b2b_idle_rdy: got %b expected 1", rdy0); end
        if (rdata0 !== 32'h0) begin nErrors++; $display("[TB] FAIL b2b_idle_data: got %h expected 0", rdata0); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] d;
        logic        r;
        do_write(0, 32'h020, 3'd0, 32'hAABBCC11);
        do_write(0, 32'h021, 3'd0, 32'hAABB22CC);
        do_write(0, 32'h022, 3'd1, 32'h4433CCDD);
        do_read(0, 32'h020, 3'd2, d, r);
        nChecks += 2;
        if (d !== 32'h44332211) begin nErrors++; $display("[TB] FAIL lanes_word: got %h expected 44332211", d); end
        if (r !== 1'b0)         begin nErrors++; $display("[TB] FAIL lanes_resp: got %b expected 0", r); end
        do_read(0, 32'h023, 3'd0, d, r);
        nChecks++;
        if (d !== 32'h44332211) begin nErrors++; $display("[TB] FAIL lanes_byte_rd: got %h expected 44332211", d); end
    endtask

    task automatic test_wait_states();
        int lows;
        do_write(1, 32'h040, 3'd2, 32'h12345678);
        drive_addr(1, 32'h040, 1'b0, 3'd2);
        tick();
        drive_idle();
        nChecks += 2;
        if (resp3 !== 1'b0)         begin nErrors++; $display("[TB] FAIL ws_wait_resp: got %b expected 0", resp3); end
        if (rdata3 !== 32'h12345678) begin nErrors++; $display("[TB] FAIL ws_wait_data: got %h expected 12345678", rdata3); end
        lows = 0;
        while (rdy3 == 1'b0 && lows < 10) begin lows++; tick(); end
        nChecks += 2;
        if (lows !== 3)             begin nErrors++; $display("[TB] FAIL ws_first_lows: got %0d expected 3", lows); end
        if (rdata3 !== 32'h12345678) begin nErrors++; $display("[TB] FAIL ws_first_data: got %h expected 12345678", rdata3); end
        drive_addr(1, 32'h040, 1'b0, 3'd2);
        tick();
        drive_idle();
        lows = 0;
        while (rdy3 == 1'b0 && lows < 10) begin lows++; tick(); end
        nChecks += 2;
        if (lows !== 3)             begin nErrors++; $display("[TB] FAIL ws_second_lows: got %0d expected 3", lows); end
        if (rdata3 !== 32'h12345678) begin nErrors++; $display("[TB] FAIL ws_second_data: got %h expected 12345678", rdata3); end
        tick();
        nChecks += 2;
        if (rdy3 !== 1'b1)   begin nErrors++; $display("[TB] FAIL ws_idle_rdy: got %b expected 1", rdy3); end
        if (rdata3 !== 32'h0) begin nErrors++; $display("[TB] FAIL ws_idle_data: got %h expected 0", rdata3); end
    endtask

    task automatic test_error();
        logic [31:0] d;
        logic        r;
        do_write(0, 32'h030, 3'd2, 32'h55667788);
        drive_addr(0, 32'h031, 1'b1, 3'd1);
        tick();
        hwdata = 32'hAAAAAAAA;
        drive_idle();
`ifdef AHB_SLV_ERR_EN
        nChecks += 2;
        if (rdy0 !== 1'b0)  begin nErrors++; $display("[TB] FAIL err1_rdy: got %b expected 0", rdy0); end
        if (resp0 !== 1'b1) begin nErrors++; $display("[TB] FAIL err1_resp: got %b expected 1", resp0); end
        tick();
        nChecks += 2;
        if (rdy0 !== 1'b1)  begin nErrors++; $display("[TB] FAIL err2_rdy: got %b expected 1", rdy0); end
        if (resp0 !== 1'b1) begin nErrors++; $display("[TB] FAIL err2_resp: got %b expected 1", resp0); end
        tick();
        nChecks++;
        if (resp0 !== 1'b0) begin nErrors++; $display("[TB] FAIL err_after_resp: got %b expected 0", resp0); end
        do_read(0, 32'h030, 3'd2, d, r);
        nChecks++;
        if (d !== 32'h55667788) begin nErrors++; $display("[TB] FAIL err_nowrite: got %h expected 55667788", d); end
        do_read(0, 32'h030, 3'd3, d, r);
        nChecks += 2;
        if (r !== 1'b1)   begin nErrors++; $display("[TB] FAIL err_size3_resp: got %b expected 1", r); end
        if (d !== 32'h0)  begin nErrors++; $display("[TB] FAIL err_size3_data: got %h expected 0", d); end
        do_read(0, 32'h032, 3'd2, d, r);
        nChecks++;
        if (r !== 1'b1)   begin nErrors++; $display("[TB] FAIL err_misword_resp: got %b expected 1", r); end
`else
        nChecks += 2;
        if (rdy0 !== 1'b1)  begin nErrors++; $display("[TB] FAIL noerr_rdy: got %b expected 1", rdy0); end
        if (resp0 !== 1'b0) begin nErrors++; $display("[TB] FAIL noerr_resp: got %b expected 0", resp0); end
        tick();
        do_read(0, 32'h030, 3'd2, d, r);
        nChecks += 2;
        if (d !== 32'h5566AAAA) begin nErrors++; $display("[TB] FAIL noerr_aligned: got %h expected 5566aaaa", d); end
        if (r !== 1'b0)         begin nErrors++; $display("[TB] FAIL noerr_rd_resp: got %b expected 0", r); end
        do_read(0, 32'h030, 3'd3, d, r);
        nChecks += 2;
        if (r !== 1'b0)         begin nErrors++; $display("[TB] FAIL noerr_size3_resp: got %b expected 0", r); end
        if (d !== 32'h5566AAAA) begin nErrors++; $display("[TB] FAIL noerr_size3_data: got %h expected 5566aaaa", d); end
        do_read(0, 32'h032, 3'd2, d, r);
        nChecks++;
        if (d !== 32'h5566AAAA) begin nErrors++; $display("[TB] FAIL noerr_misword: got %h expected 5566aaaa", d); end
`endif
    endtask

    task automatic test_idle();
        logic [31:0] d;
        logic        r;
        haddr  = 32'h010;
        hwrite = 1'b1;
        hsize  = 4'd2;
        hwdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            case (i % 3)
                0:       begin hsel0 = 1'b0; htrans = 2'b10; end
                1:       begin hsel0 = 1'b1; htrans = 2'b00; end
                default: begin hsel0 = 1'b1; htrans = 2'b01; end
            endcase
            tick();
            nChecks += 3;
            if (rdy0 !== 1'b1)   begin nErrors++; $display("[TB] FAIL idle_rdy[%0d]: got %b expected 1", i, rdy0); end
            if (resp0 !== 1'b0)  begin nErrors++; $display("[TB] FAIL idle_resp[%0d]: got %b expected 0", i, resp0); end
            if (rdata0 !== 32'h0) begin nErrors++; $display("[TB] FAIL idle_data[%0d]: got %h expected 0", i, rdata0); end
        end
        drive_idle();
        tick();
        do_read(0, 32'h010, 3'd2, d, r);
        nChecks++;
        if (d !== 32'hDEADBEEF) begin nErrors++; $display("[TB] FAIL idle_nochange: got %h expected deadbeef", d); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] d;
        logic        r;
        do_write(1, 32'h050, 3'd2, 32'hCAFEF00D);
        drive_addr(1, 32'h050, 1'b1, 3'd2);
        tick();
        hwdata = 32'h0BADBEEF;
        drive_idle();
        tick();
        nChecks++;
        if (rdy3 !== 1'b0) begin nErrors++; $display("[TB] FAIL rstw_in_wait: got %b expected 0", rdy3); end
        hreset = 1'b1;
        tick();
        hreset = 1'b0;
        nChecks += 3;
        if (rdy3 !== 1'b1)   begin nErrors++; $display("[TB] FAIL rstw_rdy: got %b expected 1", rdy3); end
        if (resp3 !== 1'b0)  begin nErrors++; $display("[TB] FAIL rstw_resp: got %b expected 0", resp3); end
        if (rdata3 !== 32'h0) begin nErrors++; $display("[TB] FAIL rstw_data: got %h expected 0", rdata3); end
        tick();
        do_read(1, 32'h050, 3'd2, d, r);
        nChecks++;
        if (d !== 32'hCAFEF00D) begin nErrors++; $display("[TB] FAIL rstw_old_data: got %h expected cafef00d", d); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_error();
        test_idle();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
